// File: rtl/rbe_streamer_arb_pkg.sv
// Shared types and helpers for the RBE streamer load/store arbiter.
// Contents:
//   arb_mode_e           - static select vs. round-robin arbitration
//   flags_streamer_arb_t - status bundle (outstanding reads, busy, error)
//   ld_st_sel_store()    - select/tag index used for the store channel (== NB_LD)
package rbe_streamer_arb_pkg;

  typedef enum logic {
    ARB_STATIC = 1'b0,
    ARB_RR     = 1'b1
  } arb_mode_e;

  localparam int unsigned OutstFlagW = 8;

  typedef struct packed {
    logic [OutstFlagW-1:0] outst;
    logic                  busy;
    logic                  err;
  } flags_streamer_arb_t;

  // The store always sits just past the last load channel.
  function automatic int unsigned ld_st_sel_store(input int unsigned nb_ld);
    return nb_ld;
  endfunction

endpackage

// File: rtl/rbe_streamer_arb_fifo.sv
// Registered FIFO with occupancy count, used for both the tag and response queues.
// Ports:
//   clk_i, rst_i (sync, active high), clear_i (sync soft clear)
//   push_i/data_i   - write side (ignored when full)
//   pop_i/data_o    - read side, data_o is the registered head (ignored when empty)
//   full_o, empty_o, count_o - occupancy status
module rbe_streamer_arb_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rbe_streamer_arb.sv
// RBE streamer load/store front-end: muxes NB_LD load channels and one store channel onto a
// single TCDM master port (static select or round-robin), tracks outstanding reads with a
// credit-limited tag FIFO and returns buffered responses in order to the issuing channel.
// Ports:
//   clk_i, rst_i (sync, active high), clear_i (soft clear), mode_i, sel_i
//   ld_*  - load channels (req/add/gnt, shared rdata, one-hot rvalid, per-channel rready)
//   st_*  - store channel (req/add/wdata/be/gnt)
//   tcdm_* - TCDM master port
//   outst_o, busy_o, err_o (sticky unexpected response), perf_stall_o
// Optional: define RBE_STREAMER_ARB_PERF_EN to build the saturating stall counter.
module rbe_streamer_arb
  import rbe_streamer_arb_pkg::*;
#(
  parameter int unsigned DW        = 128,
  parameter int unsigned AW        = 32,
  parameter int unsigned NB_LD     = 3,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned SW        = $clog2(NB_LD + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           mode_i,
  input  logic [SW-1:0]                  sel_i,
  input  logic [NB_LD-1:0]               ld_req_i,
  input  logic [NB_LD*AW-1:0]            ld_add_i,
  output logic [NB_LD-1:0]               ld_gnt_o,
  output logic [DW-1:0]                  ld_rdata_o,
  output logic [NB_LD-1:0]               ld_rvalid_o,
  input  logic [NB_LD-1:0]               ld_rready_i,
  input  logic                           st_req_i,
  input  logic [AW-1:0]                  st_add_i,
  input  logic [DW-1:0]                  st_wdata_i,
  input  logic [DW/8-1:0]                st_be_i,
  output logic                           st_gnt_o,
  output logic                           tcdm_req_o,
  output logic [AW-1:0]                  tcdm_add_o,
  output logic                           tcdm_wen_o,
  output logic [DW/8-1:0]                tcdm_be_o,
  output logic [DW-1:0]                  tcdm_data_o,
  input  logic                           tcdm_gnt_i,
  input  logic [DW-1:0]                  tcdm_r_data_i,
  input  logic                           tcdm_r_valid_i,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [31:0]                    perf_stall_o
);

  localparam int unsigned NP              = NB_LD + 1;
  localparam int unsigned OW              = $clog2(MAX_OUTST + 1);
  localparam int unsigned LD_ST_SEL_STORE = ld_st_sel_store(NB_LD);

  arb_mode_e           mode;
  flags_streamer_arb_t flags;

  logic [SW-1:0] rr_ptr_q, rr_ptr_d, lock_sel_q, lock_sel_d, win, rr_idx;
  logic          lock_q, lock_d, err_q, err_d;
  logic          win_vld, win_is_st, hs;
  logic [SW:0]   rr_sum;
  logic [NP-1:0] elig;
  logic [AW-1:0] ld_add_sel;

  logic          tag_push, tag_full, tag_empty, rsp_pop, resp_push, resp_full, resp_empty;
  logic          unexp;
  logic [SW-1:0] tag_head;
  logic [DW-1:0] resp_head;
  logic [OW-1:0] tag_count, resp_count;

  assign mode = arb_mode_e'(mode_i);

  // Winner selection; a stalled request keeps its channel until the handshake.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NB_LD; i++) elig[i] = ld_req_i[i] & ~tag_full;
    elig[NB_LD] = st_req_i;
    win     = '0;
    win_vld = 1'b0;
    rr_sum  = '0;
    rr_idx  = '0;
    if (lock_q) begin
      win     = lock_sel_q;
      win_vld = elig[lock_sel_q];
    end else if (mode == ARB_STATIC) begin
      win     = sel_i;
      win_vld = (32'(sel_i) < NP) && elig[sel_i];
    end else begin
      for (int off = 0; off < NP; off++) begin
        rr_sum = {1'b0, rr_ptr_q} + (SW+1)'(off);
        if (rr_sum >= (SW+1)'(NP)) rr_sum = rr_sum - (SW+1)'(NP);
        rr_idx = rr_sum[SW-1:0];
        if (!win_vld && elig[rr_idx]) begin
          win     = rr_idx;
          win_vld = 1'b1;
        end
      end
    end
  end

  // Request path and grants, combinational from the winner.
  always_comb begin
    win_is_st  = (win == SW'(LD_ST_SEL_STORE));
    ld_add_sel = '0;
    for (int i = 0; i < NB_LD; i++) begin
      if (win == SW'(i)) ld_add_sel = ld_add_i[i*AW +: AW];
    end
    tcdm_req_o  = win_vld;
    tcdm_add_o  = '0;
    tcdm_wen_o  = 1'b1;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    if (win_vld) begin
      if (win_is_st) begin
        tcdm_add_o  = st_add_i;
        tcdm_wen_o  = 1'b0;
        tcdm_be_o   = st_be_i;
        tcdm_data_o = st_wdata_i;
      end else begin
        tcdm_add_o = ld_add_sel;
        tcdm_be_o  = '1;
      end
    end
    hs       = win_vld & tcdm_gnt_i;
    st_gnt_o = hs & win_is_st;
    ld_gnt_o = '0;
    for (int i = 0; i < NB_LD; i++) ld_gnt_o[i] = hs & ~win_is_st & (win == SW'(i));
  end

  always_comb begin
    lock_d     = win_vld & ~tcdm_gnt_i;
    lock_sel_d = win;
    rr_ptr_d   = rr_ptr_q;
    if (hs) rr_ptr_d = (win == SW'(NB_LD)) ? '0 : win + 1'b1;
  end

  // Response side: data only belongs to us if some issued read still lacks its data.
  always_comb begin
    for (int k = 0; k < NB_LD; k++) ld_rvalid_o[k] = ~resp_empty & (tag_head == SW'(k));
    ld_rdata_o = resp_empty ? '0 : resp_head;
    rsp_pop    = |(ld_rvalid_o & ld_rready_i);
    tag_push   = hs & ~win_is_st;
    unexp      = tcdm_r_valid_i & (resp_count == tag_count);
    resp_push  = tcdm_r_valid_i & ~unexp & ~resp_full;
    err_d      = err_q | unexp;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      err_q      <= err_d;
    end
  end

  rbe_streamer_arb_fifo #(
    .Width (SW),
    .Depth (MAX_OUTST)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (tag_push),
    .data_i  (win),
    .pop_i   (rsp_pop),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  rbe_streamer_arb_fifo #(
    .Width (DW),
    .Depth (MAX_OUTST)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (resp_push),
    .data_i  (tcdm_r_data_i),
    .pop_i   (rsp_pop),
    .data_o  (resp_head),
    .full_o  (resp_full),
    .empty_o (resp_empty),
    .count_o (resp_count)
  );

  always_comb begin
    flags.outst = OutstFlagW'(tag_count);
    flags.busy  = ~tag_empty | tcdm_req_o;
    flags.err   = err_q;
  end

  assign outst_o = flags.outst[OW-1:0];
  assign busy_o  = flags.busy;
  assign err_o   = flags.err;

`ifdef RBE_STREAMER_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall;

  always_comb begin
    stall  = (tcdm_req_o & ~tcdm_gnt_i) | ((|ld_req_i) & tag_full);
    perf_d = perf_q;
    if (stall && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) perf_q <= '0;
    else                  perf_q <= perf_d;
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_rbe_streamer_arb.sv
// Self-checking bench for rbe_streamer_arb: a TCDM responder model answers reads one cycle
// after grant, load grants push expected {channel, data} into a scoreboard that is checked
// as responses are consumed.
module tb_rbe_streamer_arb;

  localparam int unsigned DW        = 128;
  localparam int unsigned AW        = 32;
  localparam int unsigned NB_LD     = 3;
  localparam int unsigned MAX_OUTST = 4;
  localparam int unsigned SW        = $clog2(NB_LD + 1);
  localparam int unsigned OW        = $clog2(MAX_OUTST + 1);
  localparam int unsigned BW        = DW / 8;
  localparam logic [BW-1:0] BeAll   = '1;
  localparam logic [DW-1:0] StData  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
`ifdef RBE_STREAMER_ARB_PERF_EN
  localparam int unsigned PerfExp = 5;
`else
  localparam int unsigned PerfExp = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_i, clear_i, mode_i;
  logic [SW-1:0]     sel_i;
  logic [NB_LD-1:0]  ld_req_i, ld_gnt_o, ld_rvalid_o, ld_rready_i;
  logic [NB_LD*AW-1:0] ld_add_i;
  logic [DW-1:0]     ld_rdata_o;
  logic              st_req_i, st_gnt_o;
  logic [AW-1:0]     st_add_i, tcdm_add_o;
  logic [DW-1:0]     st_wdata_i, tcdm_data_o, tcdm_r_data_i;
  logic [BW-1:0]     st_be_i, tcdm_be_o;
  logic              tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i;
  logic [OW-1:0]     outst_o;
  logic              busy_o, err_o;
  logic [31:0]       perf_stall_o;

  always #5 clk = ~clk;

  rbe_streamer_arb #(
    .DW        (DW),
    .AW        (AW),
    .NB_LD     (NB_LD),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .mode_i         (mode_i),
    .sel_i          (sel_i),
    .ld_req_i       (ld_req_i),
    .ld_add_i       (ld_add_i),
    .ld_gnt_o       (ld_gnt_o),
    .ld_rdata_o     (ld_rdata_o),
    .ld_rvalid_o    (ld_rvalid_o),
    .ld_rready_i    (ld_rready_i),
    .st_req_i       (st_req_i),
    .st_add_i       (st_add_i),
    .st_wdata_i     (st_wdata_i),
    .st_be_i        (st_be_i),
    .st_gnt_o       (st_gnt_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .outst_o        (outst_o),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .perf_stall_o   (perf_stall_o)
  );

  typedef struct {
    int unsigned   chan;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned glog[$];
  int          checks = 0;
  int          failures = 0;
  logic [AW-1:0] ld_add_v [NB_LD];
  logic        mute_resp = 1'b0;
  int unsigned max_outst = 0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {(DW/AW){a}} ^ {BW{8'hA5}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    ld_add_v[k] = a;
    ld_add_i[k*AW +: AW] = a;
  endtask

  // One clock cycle: sample just after inputs settle, respond to reads after the edge.
  task automatic tick();
    logic          rd_pend;
    logic [AW-1:0] rd_add;
    exp_t          e;
    #1;
    for (int k = 0; k < NB_LD; k++) begin
      if (ld_gnt_o[k]) begin
        sb.push_back('{chan: k, data: mem_data(ld_add_v[k])});
        glog.push_back(k);
      end
    end
    if (st_gnt_o) glog.push_back(NB_LD);
    rd_pend = tcdm_req_o & tcdm_gnt_i & tcdm_wen_o;
    rd_add  = tcdm_add_o;
    for (int k = 0; k < NB_LD; k++) begin
      if (ld_rvalid_o[k] && ld_rready_i[k]) begin
        if (sb.size() == 0) begin
          check("rsp_orphan", DW'(ld_rvalid_o), '0);
        end else begin
          e = sb.pop_front();
          check("rsp_chan", DW'(k), DW'(e.chan));
          check("rsp_data", ld_rdata_o, e.data);
        end
      end
    end
    if (32'(outst_o) > max_outst) max_outst = 32'(outst_o);
    @(posedge clk);
    #1;
    if (!mute_resp) begin
      tcdm_r_valid_i = rd_pend;
      tcdm_r_data_i  = rd_pend ? mem_data(rd_add) : '0;
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    sb.delete();
    glog.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n_prev;
    rst_i = 1'b1; clear_i = 1'b0; mode_i = 1'b0; sel_i = '0;
    ld_req_i = '0; ld_add_i = '0; ld_rready_i = '1;
    st_req_i = 1'b0; st_add_i = '0; st_wdata_i = '0; st_be_i = '0;
    tcdm_gnt_i = 1'b0; tcdm_r_data_i = '0; tcdm_r_valid_i = 1'b0;
    for (int k = 0; k < NB_LD; k++) ld_add_v[k] = '0;
    @(negedge clk);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("rst_req", DW'(tcdm_req_o), '0);
    check("rst_wen", DW'(tcdm_wen_o), DW'(1));
    check("rst_outst", DW'(outst_o), '0);
    check("rst_busy", DW'(busy_o), '0);
    check("rst_err", DW'(err_o), '0);
    check("rst_rvalid", DW'(ld_rvalid_o), '0);
    check("rst_perf", DW'(perf_stall_o), '0);

    // Static load on channel 1, grant always high.
    mode_i = 1'b0; sel_i = SW'(1); tcdm_gnt_i = 1'b1;
    set_addr(1, 32'h100);
    ld_req_i = 3'b010;
    #1;
    check("stat_add", DW'(tcdm_add_o), DW'(32'h100));
    check("stat_wen", DW'(tcdm_wen_o), DW'(1));
    check("stat_be", DW'(tcdm_be_o), DW'(BeAll));
    check("stat_gnt", DW'(ld_gnt_o), DW'(3'b010));
    tick();
    ld_req_i = '0;
    #1;
    check("stat_lat_t1", DW'(ld_rvalid_o), '0);
    tick();
    #1;
    check("stat_lat_t2", DW'(ld_rvalid_o), DW'(3'b010));
    check("stat_data", ld_rdata_o, mem_data(32'h100));
    tick();
    tick();
    check("stat_sb_empty", DW'(sb.size()), '0);

    // Round-robin with all channels requesting.
    do_clear();
    set_addr(0, 32'h200); set_addr(1, 32'h210); set_addr(2, 32'h220);
    st_add_i = 32'h300; st_wdata_i = StData; st_be_i = 16'h00FF;
    mode_i = 1'b1; ld_req_i = 3'b111; st_req_i = 1'b1; max_outst = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        #1;
        check("rr_st_wen", DW'(tcdm_wen_o), '0);
        check("rr_st_data", tcdm_data_o, StData);
        check("rr_st_be", DW'(tcdm_be_o), DW'(16'h00FF));
      end
      tick();
    end
    ld_req_i = '0; st_req_i = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("rr_count", DW'(glog.size()), DW'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < glog.size()) check("rr_order", DW'(glog[i]), DW'(i % 4));
    end
    check("rr_outst_max", DW'(max_outst <= MAX_OUTST), DW'(1));
    check("rr_sb_empty", DW'(sb.size()), '0);

    // Credit limit: six requests with responses held back.
    do_clear();
    mode_i = 1'b0; sel_i = '0; ld_rready_i = '0; tcdm_gnt_i = 1'b1;
    set_addr(0, 32'h400);
    ld_req_i = 3'b001;
    for (int c = 0; c < 6; c++) begin
      n_prev = glog.size();
      tick();
      if (glog.size() != n_prev) set_addr(0, ld_add_v[0] + 32'h10);
    end
    #1;
    check("cr_granted", DW'(glog.size()), DW'(4));
    check("cr_outst", DW'(outst_o), DW'(MAX_OUTST));
    check("cr_blocked", DW'(tcdm_req_o), '0);
    ld_rready_i = '1;
    for (int c = 0; c < 20 && glog.size() < 6; c++) begin
      n_prev = glog.size();
      tick();
      if (glog.size() != n_prev) set_addr(0, ld_add_v[0] + 32'h10);
    end
    ld_req_i = '0;
    for (int c = 0; c < 8; c++) tick();
    check("cr_total", DW'(glog.size()), DW'(6));
    check("cr_sb_empty", DW'(sb.size()), '0);
    check("cr_outst_end", DW'(outst_o), '0);

    // Lock: channel 2 stalled while other inputs move.
    do_clear();
    mode_i = 1'b1; tcdm_gnt_i = 1'b0;
    set_addr(0, 32'h500); set_addr(2, 32'h520);
    ld_req_i = 3'b100;
    tick();
    ld_req_i = 3'b101; sel_i = '0; mode_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lk_add", DW'(tcdm_add_o), DW'(32'h520));
      check("lk_gnt", DW'(ld_gnt_o), '0);
      tick();
      mode_i = ~mode_i;
    end
    tcdm_gnt_i = 1'b1;
    #1;
    check("lk_rel_add", DW'(tcdm_add_o), DW'(32'h520));
    check("lk_rel_gnt", DW'(ld_gnt_o), DW'(3'b100));
    tick();
    ld_req_i = '0;
    for (int c = 0; c < 4; c++) tick();
    check("lk_sb_empty", DW'(sb.size()), '0);

    // Stall counter.
    do_clear();
    mode_i = 1'b1; tcdm_gnt_i = 1'b0; st_req_i = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    #1;
    check("perf_count", DW'(perf_stall_o), DW'(PerfExp));
    st_req_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("perf_rst", DW'(perf_stall_o), '0);

    // Clear while a read is in flight; its data must be dropped and flagged.
    mode_i = 1'b0; sel_i = '0; tcdm_gnt_i = 1'b1; mute_resp = 1'b1;
    set_addr(0, 32'h600);
    ld_req_i = 3'b001;
    tick();
    ld_req_i = '0; clear_i = 1'b1;
    #1;
    check("cl_outst_pre", DW'(outst_o), DW'(1));
    tick();
    clear_i = 1'b0;
    sb.delete();
    tcdm_r_valid_i = 1'b1; tcdm_r_data_i = mem_data(32'h600);
    #1;
    check("cl_outst_clr", DW'(outst_o), '0);
    tick();
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
    #1;
    check("cl_err", DW'(err_o), DW'(1));
    check("cl_outst", DW'(outst_o), '0);
    check("cl_rvalid", DW'(ld_rvalid_o), '0);
    tick();
    tick();
    check("cl_rvalid_late", DW'(ld_rvalid_o), '0);
    check("cl_err_sticky", DW'(err_o), DW'(1));
    mute_resp = 1'b0;
    do_clear();
    #1;
    check("cl_err_cleared", DW'(err_o), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
